vs_ram_burst_reader: RTL

Read-side streaming engine for `vs_single_port_ram`. On a start command it walks a contiguous address range (base, length) through the RAM's address port. It absorbs the RAM's one-cycle registered read latency and presents the words in order on a valid/ready stream. A 2-entry output buffer gives full throughput (one word per cycle) while allowing arbitrary backpressure, with no lost or duplicated words.

---
 rtl/vs_ram_burst_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vs_ram_burst_reader.sv
// Read-side burst engine for vs_single_port_ram: walks (base, length), absorbs the
// one-cycle read latency and streams words through a 2-entry valid/ready buffer.
module vs_ram_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0]  out_left_q, out_left_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic                  v0_q, v0_d;
  logic                  v1_q, v1_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  handshake;
  logic                  issue;
  logic [1:0]            occupancy;

  // A read may issue whenever buffer + in-flight word leave a free slot, counting a pop this cycle.
  always_comb begin
    handshake = v0_q & m_ready;
    occupancy = 2'(v0_q) + 2'(v1_q) + 2'(inflight_q);
    issue     = (state_q == S_RUN) && (issue_left_q != '0) &&
                ((occupancy < 2'd2) || ((occupancy == 2'd2) && handshake));
  end

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    inflight_d   = issue;
    slot0_d      = slot0_q;
    slot1_d      = slot1_q;
    v0_d         = v0_q;
    v1_d         = v1_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d      = S_RUN;
            rd_ptr_d     = base_addr;
            issue_left_d = length;
            out_left_d   = length;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (handshake && (out_left_q == LEN_WIDTH'(1))) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(1);
      issue_left_d = issue_left_q - LEN_WIDTH'(1);
    end
    if (handshake) out_left_d = out_left_q - LEN_WIDTH'(1);

    // slot0 is the stream head; slot1 only fills while the head is stalled.
    case ({inflight_q, handshake})
      2'b01: begin
        slot0_d = slot1_q;
        v0_d    = v1_q;
        v1_d    = 1'b0;
      end
      2'b10: begin
        if (!v0_q) begin
          slot0_d = ram_rdata;
          v0_d    = 1'b1;
        end else begin
          slot1_d = ram_rdata;
          v1_d    = 1'b1;
        end
      end
      2'b11: begin
        if (v1_q) begin
          slot0_d = slot1_q;
          slot1_d = ram_rdata;
        end else begin
          slot0_d = ram_rdata;
        end
      end
      default: ;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= inflight_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      v0_q         <= v0_d;
      v1_q         <= v1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign ram_addr = rd_ptr_q;
  assign m_data   = slot0_q;
  assign m_valid  = v0_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
